uart_rx: RTL
============

# uart_rx

UART receive engine with 16x oversampling. Consumes the single-cycle oversample tick from the baud generator and recovers 8N1 frames from the serial `rx` line. Each frame is delivered as a parallel byte through a valid/ack handshake to the APB register block. Framing and overrun errors are reported as one-cycle pulses.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `OVERSAMPLE`, 16: baud ticks per bit; must be even and ≥ 8.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `baud_tick` in 1: one-`clk`-wide pulse at baud_rate × OVERSAMPLE.
- `rx` in 1: asynchronous serial input; idle high.
- `rx_ack` in 1: consumer accepts `rx_data`; only meaningful while `rx_valid`=1.
- `rx_data` out DATA_BITS: received byte, LSB = first bit on the line.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `frame_err` out 1: one-cycle pulse on a bad stop bit.
- `overrun_err` out 1: one-cycle pulse when a frame completes while the previous byte is still pending.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Reset values:**
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, `busy`=0.
  - State = IDLE; tick counter = 0; bit counter = 0.
  - Both synchronizer flops = 1.
- **Input sync:** `rx` passes through a 2-flop synchronizer (`rx_s`). All decisions use `rx_s` only.
- **Tick counter:**
  - Width $clog2(OVERSAMPLE).
  - Advances only on `baud_tick`.
  - Cleared on every state entry.
- **States:**
  - **IDLE**
    - `rx_s`=0 → START, counter cleared.
  - **START**
    - On the tick where counter = OVERSAMPLE/2−1, sample `rx_s`.
    - Sample 0 → DATA, counter cleared (sampling now aligned to mid-bit).
    - Sample 1 → glitch; return to IDLE with no error.
  - **DATA**
    - On the tick where counter = OVERSAMPLE−1, sample `rx_s` and shift it in LSB-first.
    - Bit counter increments; after DATA_BITS samples → PARITY (if enabled) or STOP.
  - **STOP**
    - On the tick where counter = OVERSAMPLE−1, sample `rx_s`.
    - Sample 1 → deliver the byte, then go to IDLE.
    - Sample 0 → `frame_err` pulse, byte discarded, go to BREAK.
  - **BREAK**
    - Wait for `rx_s`=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **Delivery:**
  - `rx_valid`=0: load `rx_data` and set `rx_valid`=1.
  - `rx_valid`=1 and `rx_ack`=0: `overrun_err` pulse; new byte dropped; old `rx_data` and `rx_valid` retained.
  - `rx_valid`=1 and `rx_ack`=1 in the same cycle: new byte loaded, `rx_valid` stays 1, no overrun.
- **Handshake:**
  - `rx_ack` while `rx_valid`=1 clears `rx_valid` next cycle.
  - `rx_ack` while `rx_valid`=0 is ignored.
  - `rx_data` is stable while `rx_valid`=1.
- Samples are taken only in cycles where `baud_tick`=1. `rx` changes between ticks are invisible except through `rx_s`.

## Timing
- Start detection: 2 `clk` cycles after `rx` falls (synchronizer), plus tick alignment.
- START confirmation occurs on the OVERSAMPLE/2-th tick after entering START.
- Each data bit is sampled OVERSAMPLE ticks after the previous sample.
- `rx_valid`, `frame_err` and `overrun_err` assert in the `clk` cycle after the stop-bit sampling tick.
- Error pulses are exactly 1 `clk` wide.
- Back-to-back frames: IDLE is entered mid-stop-bit, so a start edge arriving half a bit later is detected. No inter-frame gap is required.
- `rst` asserted mid-frame: all state returns to reset values immediately, any partial byte is lost, and no error pulses are issued.
- `baud_tick` held high continuously is legal; behaviour is then one sample step per `clk`.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - Adds input `parity_odd` (1 bit; 0 = even, 1 = odd) and output `parity_err` (1-cycle pulse, reset 0).
  - Adds a PARITY state between DATA and STOP, sampled on counter = OVERSAMPLE−1.
  - On a mismatch, `parity_err` pulses in the delivery cycle and the byte is still delivered.
- **Undefined:**
  - Neither port exists.
  - DATA goes directly to STOP.
  - Frame format is fixed 8N1 (for DATA_BITS=8).

## Test plan
- **Basic frame:** `baud_tick` every 4 `clk`; send 0xA5 in 8N1.
  - `rx_valid`=1 with `rx_data`=0xA5.
  - `rx_ack` one cycle later → `rx_valid`=0 next cycle.
- **Glitch:** `rx` low for 5 ticks, then high.
  - State returns to IDLE.
  - No `rx_valid`, no `frame_err`.
  - A following 0x3C frame is received correctly.
- **Framing error / break:** send 0x55 with stop bit = 0, then hold `rx` low for 40 ticks.
  - Exactly one `frame_err` pulse.
  - `rx_valid` stays 0.
  - After `rx` returns high, 0x81 is received.
- **Overrun:** send 0x11 then 0x22 back-to-back with no `rx_ack`.
  - `overrun_err` pulses once.
  - `rx_data` stays 0x11.
  - Repeat with `rx_ack` asserted in the delivery cycle of 0x22 → `rx_data`=0x22, no overrun.
- **Reset mid-frame:** assert `rst` after 3 data bits of 0xF0.
  - All outputs return to reset values, `busy`=0.
  - The next full frame, 0x0F, is received intact.
- **Parity (`UART_RX_PARITY_EN`):** `parity_odd`=0.
  - 0x07 with parity bit 1 → no `parity_err`.
  - 0x07 with parity bit 0 → `parity_err` pulse and `rx_data`=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver delivering frames through a valid/ack handshake.
// Optional parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 rx_ack,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE   = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state_r;
    logic                 sync1_r;
    logic                 rx_s;
    logic [CNT_W-1:0]     tick_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;

`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_r;

    // High when data plus received parity bit disagree with the selected parity sense.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic pbit, input logic odd);
        return (^data) ^ pbit ^ odd;
    endfunction
`endif

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx;
            rx_s    <= sync1_r;
        end
    end

    // Frame FSM with registered delivery, handshake and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            tick_cnt_r  <= CNT_ZERO;
            bit_cnt_r   <= BIT_ZERO;
            shift_r     <= {DATA_BITS{1'b0}};
            rx_data     <= {DATA_BITS{1'b0}};
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err   <= 1'b0;
            parity_bad_r <= 1'b0;
`endif
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            // A delivery in STOP below overrides this clear when both coincide.
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_r    <= START;
                        tick_cnt_r <= CNT_ZERO;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_cnt_r == HALF_LAST) begin
                            tick_cnt_r <= CNT_ZERO;
                            if (!rx_s) begin
                                state_r   <= DATA;
                                bit_cnt_r <= BIT_ZERO;
                            end else begin
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + CNT_ONE;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt_r == FULL_LAST) begin
                            tick_cnt_r <= CNT_ZERO;
                            shift_r    <= {rx_s, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r  <= bit_cnt_r + BIT_ONE;
                            if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state_r <= PARITY;
`else
                                state_r <= STOP;
`endif
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + CNT_ONE;
                        end
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (baud_tick) begin
                        if (tick_cnt_r == FULL_LAST) begin
                            tick_cnt_r   <= CNT_ZERO;
                            parity_bad_r <= parity_mismatch(shift_r, rx_s, parity_odd);
                            state_r      <= STOP;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + CNT_ONE;
                        end
                    end
`else
                    state_r <= IDLE;
                    busy    <= 1'b0;
`endif
                end
                STOP: begin
                    if (baud_tick) begin
                        if (tick_cnt_r == FULL_LAST) begin
                            tick_cnt_r <= CNT_ZERO;
                            if (rx_s) begin
                                // Back to IDLE at mid-stop so a following start edge is caught.
                                state_r <= IDLE;
                                busy    <= 1'b0;
                                if (!rx_valid || rx_ack) begin
                                    rx_data  <= shift_r;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun_err <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                parity_err <= parity_bad_r;
`endif
                            end else begin
                                frame_err <= 1'b1;
                                state_r   <= BREAK;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + CNT_ONE;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_r    <= IDLE;
                        tick_cnt_r <= CNT_ZERO;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tick_cnt_r <= CNT_ZERO;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
